// File: rtl/crc_attach.sv
// Forwards a serial transport block bit by bit and appends the 16-bit CRC
// (LSB first) delivered by the upstream serial CRC generator.
module crc_attach #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATA,
    input  logic             ACTIVE,
    input  logic [15:0]      CRC_IN,
    input  logic             CRC_VALID,
    output logic             SER_OUT,
    output logic             OUT_VALID,
    output logic             OUT_LAST,
    output logic [LEN_W-1:0] TB_LEN,
    output logic             BUSY,
    output logic             TIMEOUT_ERR,
    output logic             OVERRUN_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        WAIT_CRC,
        APPEND
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        crc_q, crc_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               active_q;
    logic               ser_q, ser_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q;
    logic               tmo_q, tmo_d;
    logic               ovr_q, ovr_d;

    // Next-state and registered-output logic; every output is loaded from
    // the _d values so the whole interface has exactly one register stage.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ser_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        tmo_d   = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ACTIVE) begin
                    state_d = PASS;
                    ser_d   = DATA;
                    valid_d = 1'b1;
                    len_d   = LEN_W'(1);
                end
            end
            PASS: begin
                if (ACTIVE) begin
                    ser_d   = DATA;
                    valid_d = 1'b1;
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                end else if (CRC_VALID) begin
                    crc_d   = CRC_IN;
                    idx_d   = '0;
                    state_d = APPEND;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                // Only the rising edge of a stray ACTIVE is reported; the bits are dropped.
                ovr_d = ACTIVE && !active_q;
                if (CRC_VALID) begin
                    crc_d   = CRC_IN;
                    idx_d   = '0;
                    state_d = APPEND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPEND: begin
                ovr_d   = ACTIVE && !active_q;
                ser_d   = crc_q[0];
                valid_d = 1'b1;
                crc_d   = {1'b0, crc_q[15:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == 4'd15) begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            crc_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            active_q <= 1'b0;
            ser_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            active_q <= ACTIVE;
            ser_q    <= ser_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= (state_d != IDLE);
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign SER_OUT     = ser_q;
    assign OUT_VALID   = valid_q;
    assign OUT_LAST    = last_q;
    assign TB_LEN      = len_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = tmo_q;
    assign OVERRUN_ERR = ovr_q;

endmodule

// File: tb/tb_crc_attach.sv
// Randomized self-checking bench for crc_attach: a default instance and a
// LEN_W=4 instance share all inputs; expected streams come from a TB/CRC model.
module tb_crc_attach;

    localparam int TMO = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DATA = 1'b0;
    logic        ACTIVE = 1'b0;
    logic [15:0] CRC_IN = 16'h0;
    logic        CRC_VALID = 1'b0;

    logic        SER_OUT, OUT_VALID, OUT_LAST, BUSY, TIMEOUT_ERR, OVERRUN_ERR;
    logic [15:0] TB_LEN;
    logic        satSer, satValid, satLast, satBusy, satTmo, satOvr;
    logic [3:0]  satTbLen;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic obsBit[$];
    int   obsCyc[$];
    int   lastCyc[$];
    int   tmoCyc[$];
    int   ovrCyc[$];
    logic satBit[$];
    int   satLastCnt = 0;
    int   satTmoCnt = 0;
    int   satOvrCnt = 0;

    crc_attach #(.LEN_W(16), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE),
        .CRC_IN(CRC_IN), .CRC_VALID(CRC_VALID),
        .SER_OUT(SER_OUT), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
        .TB_LEN(TB_LEN), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .OVERRUN_ERR(OVERRUN_ERR)
    );

    crc_attach #(.LEN_W(4), .TIMEOUT(TMO)) dutSat (
        .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE),
        .CRC_IN(CRC_IN), .CRC_VALID(CRC_VALID),
        .SER_OUT(satSer), .OUT_VALID(satValid), .OUT_LAST(satLast),
        .TB_LEN(satTbLen), .BUSY(satBusy),
        .TIMEOUT_ERR(satTmo), .OVERRUN_ERR(satOvr)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record everything the outputs show, tagged with the edge that produced it.
    always @(negedge CLK) begin
        if (OUT_VALID) begin
            obsBit.push_back(SER_OUT);
            obsCyc.push_back(cyc);
        end
        if (OUT_LAST) lastCyc.push_back(cyc);
        if (TIMEOUT_ERR) tmoCyc.push_back(cyc);
        if (OVERRUN_ERR) ovrCyc.push_back(cyc);
        if (satValid) satBit.push_back(satSer);
        if (satLast) satLastCnt <= satLastCnt + 1;
        if (satTmo) satTmoCnt <= satTmoCnt + 1;
        if (satOvr) satOvrCnt <= satOvrCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // One transport block: len data bits, CRC_VALID d cycles after the first
    // ACTIVE-low sample (d<0 never), optional stray ACTIVE burst during the CRC
    // append, optional reset after CRC bit 5 has been seen.
    task automatic applyStimulus(input string name, input int len, input logic [63:0] data,
                                 input int d, input int hold, input logic [15:0] crc,
                                 input int ovOff, input int ovLen, input bit doReset);
        logic expBit[$];
        int   expCyc[$];
        int   b0 = obsBit.size();
        int   l0 = lastCyc.size();
        int   tm0 = tmoCyc.size();
        int   ov0 = ovrCyc.size();
        int   s0 = satBit.size();
        int   sl0 = satLastCnt;
        int   st0 = satTmoCnt;
        int   so0 = satOvrCnt;
        bit   tmoExp = (d < 0) || (d > TMO);
        int   e0, m, tEnd, nCrc, expLen, expSatLen, nObs, nLastExp;

        for (int i = 0; i < len; i++) begin
            step();
            ACTIVE = 1'b1;
            DATA = data[i];
            expBit.push_back(data[i]);
            expCyc.push_back(cyc + 1);
        end
        step();
        ACTIVE = 1'b0;
        DATA = 1'b0;
        e0 = cyc;
        m = e0 + 1 + d;
        nCrc = tmoExp ? 0 : (doReset ? 6 : 16);
        for (int k = 0; k < nCrc; k++) begin
            expBit.push_back(crc[k]);
            expCyc.push_back(m + 1 + k);
        end
        tEnd = (tmoExp ? TMO + 1 : d + 17) + 6;

        for (int t = 0; t <= tEnd; t++) begin
            if (t > 0) step();
            CRC_VALID = (d >= 0) && (t >= d) && (t < d + hold);
            CRC_IN = CRC_VALID ? crc : 16'($urandom);
            ACTIVE = (ovOff >= 0) && (t >= d + 1 + ovOff) && (t < d + 1 + ovOff + ovLen);
            DATA = ACTIVE ? 1'($urandom) : 1'b0;
            if (tmoExp && t == TMO) checkOutput({name, ".busyBeforeTmo"}, 64'(BUSY), 64'd1);
            if (tmoExp && t == TMO + 1) checkOutput({name, ".tmoPulseBusyLow"}, 64'({TIMEOUT_ERR, BUSY}), 64'd2);
            if (doReset && t == d + 8) begin
                #1 RST = 1'b1;
                #1 checkOutput({name, ".resetZero"}, 64'({OUT_VALID, OUT_LAST, BUSY, TB_LEN, satTbLen}), 64'd0);
                #1 RST = 1'b0;
            end
        end
        ACTIVE = 1'b0;
        CRC_VALID = 1'b0;
        DATA = 1'b0;

        nObs = obsBit.size() - b0;
        checkOutput({name, ".count"}, 64'(nObs), 64'(expBit.size()));
        for (int k = 0; k < expBit.size() && k < nObs; k++) begin
            checkOutput($sformatf("%s.bit%0d", name, k), 64'(obsBit[b0 + k]), 64'(expBit[k]));
            checkOutput($sformatf("%s.cyc%0d", name, k), 64'(obsCyc[b0 + k]), 64'(expCyc[k]));
        end
        checkOutput({name, ".satCount"}, 64'(satBit.size() - s0), 64'(expBit.size()));
        for (int k = 0; k < expBit.size() && s0 + k < satBit.size(); k++) begin
            checkOutput($sformatf("%s.satBit%0d", name, k), 64'(satBit[s0 + k]), 64'(expBit[k]));
        end

        nLastExp = (nCrc == 16) ? 1 : 0;
        checkOutput({name, ".lastCount"}, 64'(lastCyc.size() - l0), 64'(nLastExp));
        if (nLastExp == 1 && lastCyc.size() > l0)
            checkOutput({name, ".lastCyc"}, 64'(lastCyc[l0]), 64'(m + 16));
        checkOutput({name, ".tmoCount"}, 64'(tmoCyc.size() - tm0), 64'(tmoExp ? 1 : 0));
        if (tmoExp && tmoCyc.size() > tm0)
            checkOutput({name, ".tmoCyc"}, 64'(tmoCyc[tm0]), 64'(e0 + 1 + TMO));
        checkOutput({name, ".ovrCount"}, 64'(ovrCyc.size() - ov0), 64'(ovOff >= 0 ? 1 : 0));
        if (ovOff >= 0 && ovrCyc.size() > ov0)
            checkOutput({name, ".ovrCyc"}, 64'(ovrCyc[ov0]), 64'(m + 1 + ovOff));
        checkOutput({name, ".satFlags"}, 64'({satLastCnt - sl0, satTmoCnt - st0, satOvrCnt - so0}),
                    64'({nLastExp, int'(tmoExp ? 1 : 0), int'(ovOff >= 0 ? 1 : 0)}));

        expLen = doReset ? 0 : len;
        expSatLen = (expLen > 15) ? 15 : expLen;
        checkOutput({name, ".tbLen"}, 64'(TB_LEN), 64'(expLen));
        checkOutput({name, ".satTbLen"}, 64'(satTbLen), 64'(expSatLen));
        checkOutput({name, ".busyIdle"}, 64'({BUSY, satBusy}), 64'd0);
    endtask

    initial begin
        logic [63:0] rdata;
        int len, d, hold, ovOff, ovLen, r;
        bit doReset;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset.outs", 64'({SER_OUT, OUT_VALID, OUT_LAST, BUSY, TIMEOUT_ERR, OVERRUN_ERR}), 64'd0);
        checkOutput("reset.tbLen", 64'({TB_LEN, satTbLen}), 64'd0);
        RST = 1'b0;

        applyStimulus("nominal", 8, 64'hA5, 17, 1, 16'h1234, -1, 0, 1'b0);
        applyStimulus("sameCycle", 11, {$urandom, $urandom}, 0, 2, 16'hFFFF, -1, 0, 1'b0);
        applyStimulus("timeout", 4, 64'h9, -1, 1, 16'h0, -1, 0, 1'b0);
        applyStimulus("overrun", 6, 64'h2D, 3, 1, 16'hBEEF, 4, 3, 1'b0);
        applyStimulus("resetMid", 5, 64'h13, 2, 1, 16'h5A5A, -1, 0, 1'b1);
        applyStimulus("afterReset", 8, 64'hA5, 17, 1, 16'h1234, -1, 0, 1'b0);
        applyStimulus("saturate", 20, 64'hF0F3C, 5, 3, 16'hC0DE, -1, 0, 1'b0);
        applyStimulus("lateOk", 3, 64'h5, TMO, 2, 16'h8001, -1, 0, 1'b0);
        applyStimulus("lateTmo", 3, 64'h6, TMO + 1, 2, 16'h7FFE, -1, 0, 1'b0);
        applyStimulus("b2bOverrun", 7, 64'h4B, 1, 1, 16'h0F0F, 15, 1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            len = $urandom_range(1, 40);
            rdata = {$urandom, $urandom};
            r = $urandom_range(0, 9);
            if (r == 0) d = -1;
            else if (r == 1) d = $urandom_range(TMO + 1, TMO + 4);
            else d = $urandom_range(0, TMO);
            hold = $urandom_range(1, 3);
            ovOff = -1;
            ovLen = 0;
            doReset = 1'b0;
            if (d >= 0 && d <= TMO) begin
                if ($urandom_range(0, 2) == 0) begin
                    ovOff = $urandom_range(0, 12);
                    ovLen = $urandom_range(1, 3);
                end else if ($urandom_range(0, 7) == 0) begin
                    doReset = 1'b1;
                end
            end
            applyStimulus($sformatf("rand%0d", n), len, rdata, d, hold, 16'($urandom),
                          ovOff, ovLen, doReset);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
